deserializer_32bit: RTL
=======================

Name: deserializer_32bit

Overview:
- Receive-side counterpart of the 32-bit LVDS frame serializer in the F2F link.
- Samples one serial bit per clock, MSB first, while the framing strobe is high. Reassembles WIDTH-bit words and presents each completed word with a one-cycle valid pulse.
- Rejects frames that are shorter or longer than WIDTH bits and reports them on an error pulse.
- Sits between the LVDS input pad logic and the RX word FIFO; shares the transmitter's clock domain, so no CDC logic is included.

Parameters:
WIDTH, 32, bits per frame; also the width of data_o.
CNT_W, 7, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all logic samples on the rising edge.
reset  input  1  asynchronous, active-high reset.
serial_i  input  1  serial data, MSB first, one bit per clock.
frame_i  input  1  frame strobe (the transmitter's busy line); high for exactly WIDTH cycles per valid frame.
data_o  output  WIDTH  last good received word; held until the next good frame.
valid_o  output  1  one-cycle pulse; data_o is new in this cycle.
frame_err_o  output  1  one-cycle pulse; the frame had a wrong length and was discarded.
lvds_busy  output  1  high while a frame is being received or checked.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, bit counter=0, shift register=0.
  - data_o=0, valid_o=0, frame_err_o=0, lvds_busy=0.
  - Reset asserted mid-frame aborts the frame: no valid_o, no frame_err_o.
- IDLE:
  - frame_i=1 at an edge: shift in serial_i, counter<=1, lvds_busy<=1, go to RECV.
  - frame_i=0: remain in IDLE.
- RECV, frame_i=1 at an edge:
  - shift <= {shift[WIDTH-2:0], serial_i}; counter++.
  - If counter becomes WIDTH, go to CHECK.
- RECV, frame_i=0 (counter < WIDTH, short frame):
  - frame_err_o pulses one cycle, shift register discarded, counter<=0, lvds_busy<=0, go to IDLE.
- CHECK (one cycle after the WIDTH-th bit):
  - frame_i=0: data_o<=shift, valid_o pulses one cycle, counter<=0, lvds_busy<=0, go to IDLE.
  - frame_i=1 (long frame): frame_err_o pulses, data_o unchanged, go to DRAIN.
- DRAIN:
  - Ignore serial_i while frame_i=1.
  - On frame_i=0: lvds_busy<=0, go to IDLE. No second error pulse.
- Latency: valid_o and the new data_o are registered on the edge after the edge that samples the last bit (2 edges after the last bit is driven).
- Minimum gap between frames is one cycle of frame_i=0, which is the CHECK cycle.
  - Back-to-back frames with a 1-cycle gap must all be received.
  - A frame_i rising edge in the cycle immediately after CHECK→IDLE is accepted normally.
- valid_o and frame_err_o are never high in the same cycle.
- data_o changes only on a valid_o pulse.
- Counter saturates and never wraps; a frame longer than WIDTH cannot alias into a valid one.
- lvds_busy is high in RECV, CHECK and DRAIN, and low in IDLE.

Test Plan:
- Reset → all outputs 0. Send 0xA5C3_0F96 MSB first with frame_i high for 32 cycles → valid_o pulses once, 2 edges after the last bit; data_o=0xA5C3_0F96; frame_err_o stays 0.
- Three frames 0xFFFF_FFFF, 0x0000_0001, 0x8000_0000, each separated by 1 idle cycle → three valid_o pulses with the exact values in order; no errors.
- Short frame: frame_i high for 20 cycles, then low → frame_err_o pulses once; no valid_o; data_o keeps its previous value. The next 32-bit frame 0x1234_5678 is received correctly.
- Long frame: frame_i high for 40 cycles → a single frame_err_o pulse in the cycle after bit 32; lvds_busy stays high until frame_i falls; no valid_o.
- Assert reset at bit 15 of a frame, release, then send 0xDEAD_BEEF → data_o=0, lvds_busy=0 during reset; no error pulse; the next frame yields 0xDEAD_BEEF.
- Loopback with serializer_32bit on the same clk (its busy drives frame_i, its serial output drives serial_i): 1000 random words → every word received in order; zero frame_err_o pulses.

Source files
------------

// File: rtl/deserializer_32bit_if.sv
// Serial receive bus of the F2F link: line side (serial/frame) in, word side out.
interface deserializer_32bit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             serial_i;
  logic             frame_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             frame_err_o;
  logic             lvds_busy;

  // Drives the line and observes received words (pad logic / testbench side).
  modport master (
    output serial_i,
    output frame_i,
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  lvds_busy
  );

  // The deserializer itself.
  modport slave (
    input  serial_i,
    input  frame_i,
    output data_o,
    output valid_o,
    output frame_err_o,
    output lvds_busy
  );

endinterface

// File: rtl/deserializer_32bit.sv
// Frame deserializer for the F2F LVDS link. Shifts in one bit per clock (MSB first)
// while frame_i is high, publishes exactly-WIDTH-bit frames with a one-cycle valid
// pulse and flags short or long frames with a one-cycle error pulse.
module deserializer_32bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 7  // 2**CNT_W must exceed WIDTH
) (
  input logic                 clk,
  input logic                 reset,
  deserializer_32bit_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCheck,
    StDrain
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   data_q;
  logic               valid_q;
  logic               err_q;
  logic               busy_q;

  // Frame FSM with registered outputs; counter only advances in StRecv and leaves
  // that state on reaching WIDTH, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.frame_i) begin
            shift_q <= {shift_q[WIDTH-2:0], bus.serial_i};
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
            state_q <= StRecv;
          end
        end
        StRecv: begin
          if (bus.frame_i) begin
            shift_q <= {shift_q[WIDTH-2:0], bus.serial_i};
            cnt_q   <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= StCheck;
            end
          end else begin
            // Short frame: discard partial word.
            err_q   <= 1'b1;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StCheck: begin
          if (!bus.frame_i) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            // Long frame: report once, then swallow the rest of it in StDrain.
            err_q   <= 1'b1;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!bus.frame_i) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.frame_err_o = err_q;
  assign bus.lvds_busy   = busy_q;

endmodule
